glyph_row_scheduler: RTL and testbench
======================================

Name: glyph_row_scheduler

Overview:
- Time-multiplexes one shared glyph ROM (digit/colon bitmaps, 20 px wide) among the eight on-screen clock character slots: HH:MM:SS.
- During each horizontal blank it fetches the next scanline's row for every slot into a shadow buffer, then commits the buffer at line end.
- The pixel writer reads stable per-slot row bits for the whole visible line.
- Time digits are snapshotted once per frame so the displayed time never tears mid-frame.

Parameters:
- VBLOCK, 250, first scanline of the digit band; the band is 32 lines.
- FETCH_H, 785, hcount at which fetching of the next line starts.
- COMMIT_H, 799, hcount (last of the line) at which the shadow buffer is copied to the output.
- V_LAST, 521, last vcount value; the next value is 0.
- ROM_LAT, 1, ROM read latency in cycles; legal range 1..4.
- COLON_CODE, 10, ROM digit code for the colon glyph.

Ports:
- clk_25MHz  in  1  pixel clock
- rst  in  1  asynchronous, active-low reset
- hcount  in  10  horizontal pixel counter, 0..799
- vcount  in  10  vertical line counter, 0..V_LAST
- hr_bcd  in  8  hours BCD, tens in [7:4]
- min_bcd  in  8  minutes BCD, tens in [7:4]
- sec_bcd  in  8  seconds BCD, tens in [7:4]
- rom_req  out  1  ROM read strobe, one read per asserted cycle
- rom_digit  out  4  ROM glyph code
- rom_row  out  5  ROM glyph row, 0..31
- rom_data  in  20  ROM row bitmap, valid ROM_LAT cycles after rom_req; bit 19 = leftmost pixel
- slot_bits  out  160  committed rows; slot 0 in [159:140] through slot 7 in [19:0]
- line_active  out  1  committed line lies inside the digit band
- fetch_busy  out  1  fetch sequence in progress
- overrun  out  1  sticky: commit reached before fetch completed

Behaviour:
- Reset while rst=0, asynchronous:
  - slot_bits=0, line_active=0, rom_req=0, rom_digit=0, rom_row=0, fetch_busy=0, overrun=0.
  - Snapshot registers = 0; shadow buffer = 0; FSM in IDLE.
- Snapshot:
  - In the cycle where hcount==0 and vcount==0, latch hr_bcd, min_bcd, sec_bcd.
  - Slot codes: 0 hr tens, 1 hr units, 2 COLON_CODE, 3 min tens, 4 min units, 5 COLON_CODE, 6 sec tens, 7 sec units.
  - BCD input changes at any other time have no effect until the next snapshot.
- Next line: nv = (vcount==V_LAST) ? 0 : vcount+1. In band when VBLOCK <= nv <= VBLOCK+31; row = nv-VBLOCK, truncated to 5 bits.
- FSM states IDLE, ISSUE, WAIT, COMMIT:
  - IDLE -> ISSUE at hcount==FETCH_H, only if nv is in band. Otherwise stay in IDLE and clear the shadow buffer to 0.
  - ISSUE: 8 consecutive cycles, rom_req=1 each cycle, rom_digit = code of slot k (k=0..7), rom_row = row. fetch_busy=1 from ISSUE entry until the last capture.
  - Return tracking: a ROM_LAT-deep valid/slot-index pipeline; rom_data is written into shadow[slot] when the tagged valid emerges.
  - ISSUE -> WAIT after slot 7 is issued. WAIT -> COMMIT when the slot-7 data is captured.
  - COMMIT waits for hcount==COMMIT_H, then returns to IDLE.
- Commit, every line at hcount==COMMIT_H regardless of state:
  - slot_bits <= shadow; line_active <= nv in band.
  - If the FSM is still in ISSUE or WAIT: set overrun=1, abort the fetch, go to IDLE. Partially filled shadow is committed as-is.
- rom_req=0 in every state except ISSUE; rom_digit and rom_row hold their last values otherwise.
- Latency: with ROM_LAT=1, the last capture occurs at FETCH_H+9. The default margin to COMMIT_H is 5 cycles.
- Frame wrap: vcount==V_LAST computes nv=0, which is out of band.
- Reset asserted mid-fetch: immediate clear. After release, the next valid fetch starts at the next FETCH_H.

Test Plan:
- Reset release, hr/min/sec = 0x12/0x34/0x56, run to frame start, then to line 249 at hcount 785:
  - 8 rom_req pulses with rom_digit 1,2,10,3,4,10,5,6 and rom_row=0.
  - At hcount 799: slot_bits equals the eight returned rows and line_active=1.
- Line 100 at hcount 785: no rom_req; at hcount 799 slot_bits=0 and line_active=0.
- Change sec_bcd to 0x57 on line 260: fetches on the remainder of the frame still use code 6. After the next (0,0) snapshot, slot 7 code is 7.
- Last band line: vcount 280 fetches rom_row=31; vcount 281 commits line_active=0; vcount 521 to 0 wrap fetches nothing.
- ROM_LAT=4 build: last capture at FETCH_H+12; overrun stays 0. Force the ROM valid late so it misses COMMIT_H: overrun=1 and stays 1 until reset.
- Assert rst at FETCH_H+3: all outputs are 0 within the same cycle. Release: the following in-band line fetches normally.

Source files
------------

// File: rtl/glyph_row_scheduler.sv
// glyph_row_scheduler: fetches next-line glyph rows for eight clock slots from a shared ROM during hblank
module glyph_row_scheduler #(
    parameter int VBLOCK     = 250,
    parameter int FETCH_H    = 785,
    parameter int COMMIT_H   = 799,
    parameter int V_LAST     = 521,
    parameter int ROM_LAT    = 1,
    parameter int COLON_CODE = 10
) (
    input  logic         clk_25MHz,
    input  logic         rst,
    input  logic [9:0]   hcount,
    input  logic [9:0]   vcount,
    input  logic [7:0]   hr_bcd,
    input  logic [7:0]   min_bcd,
    input  logic [7:0]   sec_bcd,
    output logic         rom_req,
    output logic [3:0]   rom_digit,
    output logic [4:0]   rom_row,
    input  logic [19:0]  rom_data,
    output logic [159:0] slot_bits,
    output logic         line_active,
    output logic         fetch_busy,
    output logic         overrun
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, COMMIT} state_t;

    localparam logic [9:0] VB    = 10'(VBLOCK);
    localparam logic [9:0] VE    = 10'(VBLOCK + 31);
    localparam logic [9:0] FH    = 10'(FETCH_H);
    localparam logic [9:0] CH    = 10'(COMMIT_H);
    localparam logic [9:0] VL    = 10'(V_LAST);
    localparam logic [3:0] COLON = 4'(COLON_CODE);

    state_t                    state, state_n;
    logic [7:0]                hr, mn, sc;
    logic [0:7][3:0]           codes;
    logic [0:7][19:0]          shadow;
    logic [2:0]                k, k_n;
    logic [ROM_LAT-1:0]        vld;
    logic [ROM_LAT-1:0][2:0]   tag;
    logic [9:0]                nv;
    logic [4:0]                row;
    logic                      in_band, at_fetch, at_commit, cap_last, abort, clr;

    assign codes      = {hr[7:4], hr[3:0], COLON, mn[7:4], mn[3:0], COLON, sc[7:4], sc[3:0]};
    assign nv         = (vcount == VL) ? 10'd0 : vcount + 10'd1;
    assign in_band    = nv >= VB && nv <= VE;
    assign row        = 5'(nv - VB);
    assign at_fetch   = hcount == FH;
    assign at_commit  = hcount == CH;
    assign k_n        = (state == ISSUE) ? k + 3'd1 : 3'd0;
    assign cap_last   = vld[ROM_LAT-1] && tag[ROM_LAT-1] == 3'd7;
    assign fetch_busy = state == ISSUE || state == WAIT;
    assign abort      = at_commit && fetch_busy;
    assign clr        = state == IDLE && at_fetch && !in_band;

    // Latch the displayed time once per frame so a line never mixes two times
    always_ff @(posedge clk_25MHz or negedge rst) begin
        if (!rst) begin
            hr <= '0;
            mn <= '0;
            sc <= '0;
        end else if (hcount == 10'd0 && vcount == 10'd0) begin
            hr <= hr_bcd;
            mn <= min_bcd;
            sc <= sec_bcd;
        end
    end

    // Next-state: a late fetch is cut off at line end so the line still commits on time
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = (at_fetch && in_band) ? ISSUE : IDLE;
            ISSUE:   state_n = (k == 3'd7) ? WAIT : ISSUE;
            WAIT:    state_n = cap_last ? COMMIT : WAIT;
            COMMIT:  state_n = at_commit ? IDLE : COMMIT;
            default: state_n = IDLE;
        endcase
        if (abort) state_n = IDLE;
    end

    // State register and ROM request outputs, which hold their last address when idle
    always_ff @(posedge clk_25MHz or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            k         <= '0;
            rom_req   <= 1'b0;
            rom_digit <= '0;
            rom_row   <= '0;
        end else begin
            state   <= state_n;
            k       <= k_n;
            rom_req <= state_n == ISSUE;
            if (state_n == ISSUE) begin
                rom_digit <= codes[k_n];
                rom_row   <= row;
            end
        end
    end

    // Track outstanding reads and drop returned rows into the shadow slot they were issued for
    always_ff @(posedge clk_25MHz or negedge rst) begin
        if (!rst) begin
            vld    <= '0;
            tag    <= '0;
            shadow <= '0;
        end else begin
            if (abort) begin
                vld <= '0;
            end else begin
                vld[0] <= state == ISSUE;
                for (int i = ROM_LAT - 1; i > 0; i--) vld[i] <= vld[i-1];
            end
            tag[0] <= k;
            for (int i = ROM_LAT - 1; i > 0; i--) tag[i] <= tag[i-1];
            if (clr) shadow <= '0;
            else if (vld[ROM_LAT-1]) shadow[tag[ROM_LAT-1]] <= rom_data;
        end
    end

    // Line-end commit: publish the shadow and flag any fetch that failed to finish
    always_ff @(posedge clk_25MHz or negedge rst) begin
        if (!rst) begin
            slot_bits   <= '0;
            line_active <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (at_commit) begin
                slot_bits   <= shadow;
                line_active <= in_band;
            end
            overrun <= overrun | abort;
        end
    end
endmodule

// File: tb/tb_glyph_row_scheduler.sv
// tb_glyph_row_scheduler: scoreboard bench for the glyph row scheduler at ROM latency 1, 4 and a too-late fetch
module tb_glyph_row_scheduler;
    logic clk_25MHz = 1'b0;
    always #20 clk_25MHz = ~clk_25MHz;

    logic         rst = 1'b0;
    logic [9:0]   hcount = 10'd0, vcount = 10'd100;
    logic [7:0]   hr_bcd = 8'h00, min_bcd = 8'h00, sec_bcd = 8'h00;

    logic         req1, la1, fb1, ov1;
    logic [3:0]   dig1;
    logic [4:0]   row1;
    logic [19:0]  rd1;
    logic [159:0] bits1;
    logic         req4, la4, fb4, ov4;
    logic [3:0]   dig4;
    logic [4:0]   row4;
    logic [19:0]  rd4;
    logic [159:0] bits4;
    logic         reql, lal, fbl, ovl;
    logic [3:0]   digl;
    logic [4:0]   rowl;
    logic [19:0]  rdl;
    logic [159:0] bitsl;

    localparam logic [19:0] JUNK = 20'hDEAD5;

    glyph_row_scheduler dut (
        .clk_25MHz(clk_25MHz), .rst(rst), .hcount(hcount), .vcount(vcount),
        .hr_bcd(hr_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
        .rom_req(req1), .rom_digit(dig1), .rom_row(row1), .rom_data(rd1),
        .slot_bits(bits1), .line_active(la1), .fetch_busy(fb1), .overrun(ov1)
    );

    glyph_row_scheduler #(.ROM_LAT(4)) dut4 (
        .clk_25MHz(clk_25MHz), .rst(rst), .hcount(hcount), .vcount(vcount),
        .hr_bcd(hr_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
        .rom_req(req4), .rom_digit(dig4), .rom_row(row4), .rom_data(rd4),
        .slot_bits(bits4), .line_active(la4), .fetch_busy(fb4), .overrun(ov4)
    );

    glyph_row_scheduler #(.ROM_LAT(4), .FETCH_H(790)) dut_late (
        .clk_25MHz(clk_25MHz), .rst(rst), .hcount(hcount), .vcount(vcount),
        .hr_bcd(hr_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
        .rom_req(reql), .rom_digit(digl), .rom_row(rowl), .rom_data(rdl),
        .slot_bits(bitsl), .line_active(lal), .fetch_busy(fbl), .overrun(ovl)
    );

    function automatic logic [19:0] rom_f(input logic [3:0] d, input logic [4:0] r);
        return {d, r, ~r, 2'b10, d};
    endfunction

    logic [19:0] p4 [4];
    logic [19:0] pl [4];

    always @(posedge clk_25MHz) rd1 <= req1 ? rom_f(dig1, row1) : JUNK;

    always @(posedge clk_25MHz) begin
        p4[0] <= req4 ? rom_f(dig4, row4) : JUNK;
        for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
    end

    always @(posedge clk_25MHz) begin
        pl[0] <= reql ? rom_f(digl, rowl) : JUNK;
        for (int j = 1; j < 4; j++) pl[j] <= pl[j-1];
    end

    assign rd4 = p4[3];
    assign rdl = pl[3];

    int          n_cmp = 0, n_bad = 0;
    logic [7:0]  s_hr = 8'h00, s_mn = 8'h00, s_sc = 8'h00;
    bit          late_ovr = 1'b0, late_fresh = 1'b1;

    function automatic logic [3:0] code_of(input int k);
        logic [3:0] c [8];
        c = '{s_hr[7:4], s_hr[3:0], 4'd10, s_mn[7:4], s_mn[3:0], 4'd10, s_sc[7:4], s_sc[3:0]};
        return c[k];
    endfunction

    task automatic snapshot(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        hr_bcd = h;
        min_bcd = m;
        sec_bcd = s;
        hcount = 10'd0;
        vcount = 10'd0;
        @(posedge clk_25MHz); #1;
        s_hr = h;
        s_mn = m;
        s_sc = s;
        hcount = 10'd1;
    endtask

    task automatic run_line(input int v);
        int           nv;
        bit           inb;
        logic [4:0]   r;
        logic [159:0] eb, el;
        logic [8:0]   q [$];
        logic [8:0]   e;
        nv = (v == 521) ? 0 : v + 1;
        inb = nv >= 250 && nv <= 281;
        r = 5'(nv - 250);
        eb = '0;
        if (inb) begin
            for (int k = 0; k < 8; k++) begin
                q.push_back({code_of(k), r});
                eb = {eb[139:0], rom_f(code_of(k), r)};
            end
        end
        el = {eb[159:80], 80'b0};
        for (int h = 780; h < 800; h++) begin
            hcount = 10'(h);
            vcount = 10'(v);
            if (req1) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL extra_req v=%0d h=%0d: got digit %0d row %0d, required no request", v, h, dig1, row1);
                end else begin
                    e = q.pop_front();
                    if ({dig1, row1} !== e) begin
                        n_bad++;
                        $display("FAIL req_addr v=%0d h=%0d: got digit %0d row %0d, required digit %0d row %0d", v, h, dig1, row1, e[8:5], e[4:0]);
                    end
                end
            end
            if (inb && (h == 794 || h == 795)) begin
                n_cmp++;
                if (fb1 !== (h == 794)) begin
                    n_bad++;
                    $display("FAIL busy_lat1 v=%0d h=%0d: got %0b, required %0b", v, h, fb1, h == 794);
                end
            end
            if (inb && (h == 797 || h == 798)) begin
                n_cmp++;
                if (fb4 !== (h == 797)) begin
                    n_bad++;
                    $display("FAIL busy_lat4 v=%0d h=%0d: got %0b, required %0b", v, h, fb4, h == 797);
                end
            end
            @(posedge clk_25MHz); #1;
        end
        hcount = 10'd0;
        vcount = 10'(nv);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL missing_req v=%0d: got %0d fewer requests than required", v, q.size());
        end
        n_cmp++;
        if (bits1 !== eb) begin
            n_bad++;
            $display("FAIL slot_bits v=%0d: got %h, required %h", v, bits1, eb);
        end
        n_cmp++;
        if (la1 !== inb) begin
            n_bad++;
            $display("FAIL line_active v=%0d: got %0b, required %0b", v, la1, inb);
        end
        n_cmp++;
        if (bits4 !== eb || la4 !== inb) begin
            n_bad++;
            $display("FAIL lat4_commit v=%0d: got %h/%0b, required %h/%0b", v, bits4, la4, eb, inb);
        end
        n_cmp++;
        if (ov1 !== 1'b0 || ov4 !== 1'b0) begin
            n_bad++;
            $display("FAIL overrun_clean v=%0d: got %0b/%0b, required 0/0", v, ov1, ov4);
        end
        if (inb) late_ovr = 1'b1;
        n_cmp++;
        if (ovl !== late_ovr) begin
            n_bad++;
            $display("FAIL overrun_late v=%0d: got %0b, required %0b", v, ovl, late_ovr);
        end
        if (inb && late_fresh) begin
            late_fresh = 1'b0;
            n_cmp++;
            if (bitsl !== el) begin
                n_bad++;
                $display("FAIL late_partial v=%0d: got %h, required %h", v, bitsl, el);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(posedge clk_25MHz);
        #1;
        n_cmp++;
        if ({req1, dig1, row1, fb1, la1, ov1} !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_ctl: got req %0b digit %0d row %0d busy %0b active %0b ovr %0b, required all 0", req1, dig1, row1, fb1, la1, ov1);
        end
        n_cmp++;
        if (bits1 !== 160'd0 || bits4 !== 160'd0 || bitsl !== 160'd0) begin
            n_bad++;
            $display("FAIL reset_bits: got %h, required 0", bits1);
        end
        rst = 1'b1;
        @(posedge clk_25MHz); #1;
    endtask

    task automatic test_band_fetch;
        snapshot(8'h12, 8'h34, 8'h56);
        run_line(249);
    endtask

    task automatic test_out_of_band;
        run_line(100);
    endtask

    task automatic test_no_tear;
        run_line(259);
        sec_bcd = 8'h57;
        run_line(260);
        run_line(270);
        snapshot(8'h12, 8'h34, 8'h57);
        run_line(249);
    endtask

    task automatic test_band_edges;
        run_line(280);
        run_line(281);
        run_line(521);
    endtask

    task automatic test_reset_mid_fetch;
        for (int h = 780; h < 788; h++) begin
            hcount = 10'(h);
            vcount = 10'd249;
            @(posedge clk_25MHz); #1;
        end
        hcount = 10'd788;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({req1, dig1, row1, fb1, la1, ov1} !== 13'd0) begin
            n_bad++;
            $display("FAIL midreset_ctl: got req %0b digit %0d row %0d busy %0b active %0b ovr %0b, required all 0", req1, dig1, row1, fb1, la1, ov1);
        end
        n_cmp++;
        if (bits1 !== 160'd0 || ovl !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_state: got bits %h late_ovr %0b, required 0 and 0", bits1, ovl);
        end
        s_hr = 8'h00;
        s_mn = 8'h00;
        s_sc = 8'h00;
        late_ovr = 1'b0;
        late_fresh = 1'b1;
        for (int h = 788; h < 800; h++) begin
            hcount = 10'(h);
            if (h == 795) rst = 1'b1;
            n_cmp++;
            if (req1 !== 1'b0) begin
                n_bad++;
                $display("FAIL midreset_req h=%0d: got 1, required 0", h);
            end
            @(posedge clk_25MHz); #1;
        end
        hcount = 10'd0;
        vcount = 10'd250;
        n_cmp++;
        if (bits1 !== 160'd0 || la1 !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_commit: got %h/%0b, required 0/1", bits1, la1);
        end
    endtask

    task automatic test_back_to_back;
        snapshot(8'h23, 8'h59, 8'h08);
        run_line(249);
        run_line(250);
        run_line(251);
    endtask

    initial begin
        test_reset;
        test_band_fetch;
        test_out_of_band;
        test_no_tear;
        test_band_edges;
        test_reset_mid_fetch;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
